// File: rtl/pwm_capture_if.sv
// -----------------------------------------------------------------------------
// pwm_capture_if
// Bundles the PWM input line and the registered measurement result of
// pwm_capture so the capture block and whatever drives or observes it share
// one port.
//
//   pwm_in         PWM waveform into the capture block (asynchronous)
//   period_cycles  cycles between consecutive rising edges
//   high_cycles    cycles from a rising edge to the following falling edge
//   duty_percent   floor(high*100/period), 0..100
//   meas_valid     one-cycle strobe, all results updated in that cycle
//   stuck          high while the reported result is a timeout result
//   overrun        one-cycle strobe, a completed measurement was dropped
//
// Modports: master = PWM source / result observer, slave = capture block.
// -----------------------------------------------------------------------------
interface pwm_capture_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 pwm_in;
   logic [CNT_WIDTH-1:0] period_cycles;
   logic [CNT_WIDTH-1:0] high_cycles;
   logic [6:0]           duty_percent;
   logic                 meas_valid;
   logic                 stuck;
   logic                 overrun;

   modport master (
      output pwm_in,
      input  period_cycles, high_cycles, duty_percent, meas_valid, stuck, overrun
   );

   modport slave (
      input  pwm_in,
      output period_cycles, high_cycles, duty_percent, meas_valid, stuck, overrun
   );
endinterface

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Samples an incoming PWM waveform, measures period and high time in clock
// cycles and (optionally) derives the duty cycle in integer percent.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    pwm_capture_if.slave: pwm_in in, measurement results out
//
// Build option:
//   PWM_CAPTURE_PERCENT_EN  defined  -> sequential restoring divider computes
//                                       duty_percent; result strobes
//                                       CNT_WIDTH+8 cycles after capture and
//                                       captures arriving while it is busy
//                                       are dropped with an overrun strobe.
//                           undefined -> no divider, duty_percent reads 0
//                                       (stuck results still 0/100), result
//                                       strobes the cycle after capture.
// -----------------------------------------------------------------------------
module pwm_capture #(
   parameter int CLK_FREQUENCY  = 33_330_000,
   parameter int FREQUENCY      = 500_000,
   parameter int CNT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 4 * (CLK_FREQUENCY / FREQUENCY)
) (
   input  logic          clk,
   input  logic          rst_n,
   pwm_capture_if.slave  bus
);

   localparam int                   IW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0]        TIMEOUT_VAL = IW'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

   state_t               r_state, w_state_next;
   logic                 r_s1, r_s2, r_s3;
   logic                 w_rise, w_fall;
   logic [CNT_WIDTH-1:0] r_period_cnt, r_high_cnt;
   logic [CNT_WIDTH-1:0] w_period_next, w_high_next;
   logic [IW-1:0]        r_idle_cnt;
   logic                 r_timed_out;
   logic                 w_timeout;
   logic                 w_capture;

   logic [CNT_WIDTH-1:0] r_period_out, r_high_out;
   logic [6:0]           r_duty_out;
   logic                 r_meas_valid, r_stuck, r_overrun;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // Two synchronizer flops plus a history flop: both edges see the same
   // fixed latency, so the measured counts are exact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.pwm_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;

   // An edge in the same cycle always wins over the timeout. r_timed_out
   // limits a stuck episode to a single result.
   assign w_timeout = (r_idle_cnt == TIMEOUT_VAL) && !r_timed_out && !w_rise && !w_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt  <= '0;
         r_timed_out <= 1'b0;
      end else if (w_rise || w_fall) begin
         r_idle_cnt  <= '0;
         r_timed_out <= 1'b0;
      end else begin
         if (r_idle_cnt != TIMEOUT_VAL)
            r_idle_cnt <= r_idle_cnt + IW'(1);
         if (w_timeout)
            r_timed_out <= 1'b1;
      end
   end

   // Edge FSM state and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_period_cnt <= w_period_next;
         r_high_cnt   <= w_high_next;
      end
   end

   // The counters start at 1 on the rise, so the values held at the next
   // rise are exactly the cycle distances between the detected edges.
   always_comb begin
      w_state_next  = r_state;
      w_period_next = r_period_cnt;
      w_high_next   = r_high_cnt;
      w_capture     = 1'b0;
      if (w_timeout) begin
         w_state_next  = ST_IDLE;
         w_period_next = '0;
         w_high_next   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_period_next = '0;
               w_high_next   = '0;
               if (w_rise) begin
                  w_state_next  = ST_HIGH;
                  w_period_next = CNT_ONE;
                  w_high_next   = CNT_ONE;
               end
            end
            ST_HIGH: begin
               w_period_next = sat_inc(r_period_cnt);
               if (w_fall)
                  w_state_next = ST_LOW;   // high time frozen from here
               else
                  w_high_next = sat_inc(r_high_cnt);
            end
            ST_LOW: begin
               // a fall while low cannot be a real edge and is ignored
               if (w_rise) begin
                  w_capture     = 1'b1;
                  w_state_next  = ST_HIGH;
                  w_period_next = CNT_ONE;
                  w_high_next   = CNT_ONE;
               end else begin
                  w_period_next = sat_inc(r_period_cnt);
               end
            end
            default: begin
               w_state_next  = ST_IDLE;
               w_period_next = '0;
               w_high_next   = '0;
            end
         endcase
      end
   end

`ifdef PWM_CAPTURE_PERCENT_EN
   localparam int DW = CNT_WIDTH + 7;      // width of high*100
   localparam int CW = $clog2(DW + 1);

   logic [DW-1:0]        r_quo;            // dividend shifts out, quotient shifts in
   logic [CNT_WIDTH-1:0] r_rem;
   logic [CNT_WIDTH-1:0] r_res_period, r_res_high;
   logic [CW-1:0]        r_div_cnt;
   logic                 r_div_busy, r_div_done;
   logic [CNT_WIDTH:0]   w_shift;
   logic [DW-1:0]        w_dividend;

   assign w_dividend = DW'(r_high_cnt) * DW'(100);
   assign w_shift    = {r_rem, r_quo[DW-1]};

   // Restoring divider, one quotient bit per cycle. The remainder is always
   // below the divisor, so the trial difference fits back into r_rem.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quo        <= '0;
         r_rem        <= '0;
         r_res_period <= '0;
         r_res_high   <= '0;
         r_div_cnt    <= '0;
         r_div_busy   <= 1'b0;
         r_div_done   <= 1'b0;
      end else begin
         r_div_done <= 1'b0;
         if (r_div_busy) begin
            if (w_shift >= {1'b0, r_res_period}) begin
               r_rem <= CNT_WIDTH'(w_shift - {1'b0, r_res_period});
               r_quo <= {r_quo[DW-2:0], 1'b1};
            end else begin
               r_rem <= w_shift[CNT_WIDTH-1:0];
               r_quo <= {r_quo[DW-2:0], 1'b0};
            end
            r_div_cnt <= r_div_cnt - CW'(1);
            if (r_div_cnt == CW'(1)) begin
               r_div_busy <= 1'b0;
               r_div_done <= 1'b1;
            end
         end else if (w_capture) begin
            r_quo        <= w_dividend;
            r_rem        <= '0;
            r_res_period <= r_period_cnt;
            r_res_high   <= r_high_cnt;
            r_div_cnt    <= CW'(DW);
            r_div_busy   <= 1'b1;
         end
      end
   end
`endif

   // Result registers. A stuck result takes priority over a normal one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period_out <= '0;
         r_high_out   <= '0;
         r_duty_out   <= '0;
         r_meas_valid <= 1'b0;
         r_stuck      <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         r_overrun    <= 1'b0;
         if (w_timeout) begin
            r_period_out <= '0;
            r_high_out   <= '0;
            r_duty_out   <= r_s2 ? 7'd100 : 7'd0;
            r_stuck      <= 1'b1;
            r_meas_valid <= 1'b1;
         end
`ifdef PWM_CAPTURE_PERCENT_EN
         else if (r_div_done) begin
            r_period_out <= r_res_period;
            r_high_out   <= r_res_high;
            r_duty_out   <= r_quo[6:0];
            r_stuck      <= 1'b0;
            r_meas_valid <= 1'b1;
         end
         if (w_capture && r_div_busy)
            r_overrun <= 1'b1;
`else
         else if (w_capture) begin
            r_period_out <= r_period_cnt;
            r_high_out   <= r_high_cnt;
            r_duty_out   <= 7'd0;
            r_stuck      <= 1'b0;
            r_meas_valid <= 1'b1;
         end
`endif
      end
   end

   assign bus.period_cycles = r_period_out;
   assign bus.high_cycles   = r_high_out;
   assign bus.duty_percent  = r_duty_out;
   assign bus.meas_valid    = r_meas_valid;
   assign bus.stuck         = r_stuck;
   assign bus.overrun       = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
// Drives PWM waveforms into pwm_capture and checks every result strobe and
// overrun strobe against a reference computed from the recorded pin edge
// times: period = distance between rises, high = rise-to-fall distance,
// duty = floor(high*100/period), result time = rise + 3 (detect) + latency.
// -----------------------------------------------------------------------------
module tb_pwm_capture;
   localparam int CW = 32;
`ifdef PWM_CAPTURE_PERCENT_EN
   localparam int LAT = CW + 8;
   localparam bit PCT = 1'b1;
`else
   localparam int LAT = 0;
   localparam bit PCT = 1'b0;
`endif
   localparam int STUCK_LAT = 268;   // detect (3) + timeout count (264) + 1

   typedef struct packed {
      int   t;
      int   period;
      int   high;
      int   duty;
      logic stuck;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_capture_if #(.CNT_WIDTH(CW)) bus();
   pwm_capture #(.CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   res_t obs_q[$];
   res_t exp_q[$];
   int   obs_ovr[$];
   int   exp_ovr[$];
   int   rises[$];
   int   falls[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.meas_valid)
            obs_q.push_back('{cyc, int'(bus.period_cycles), int'(bus.high_cycles),
                              int'(bus.duty_percent), bus.stuck});
         if (bus.overrun)
            obs_ovr.push_back(cyc);
      end
   end

   // Drive a level for n cycles, recording the cycle of each pin edge.
   task automatic seg(input bit lvl, input int n);
      if (lvl && !bus.pwm_in) rises.push_back(cyc);
      else if (!lvl && bus.pwm_in) falls.push_back(cyc);
      bus.pwm_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.pwm_in = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete(); exp_q.delete(); obs_ovr.delete(); exp_ovr.delete();
      rises.delete(); falls.delete();
   endtask

   // Reference model: one expected result per pair of consecutive rises;
   // with the divider, a capture arriving less than LAT cycles after the
   // last accepted one is dropped and reported as overrun instead.
   task automatic build_expected();
      int last = -100000;
      for (int k = 0; k + 1 < rises.size(); k++) begin
         int p   = rises[k+1] - rises[k];
         int h   = falls[k] - rises[k];
         int cap = rises[k+1] + 3;
         if (cap - last >= LAT) begin
            exp_q.push_back('{cap + LAT, p, h, PCT ? (h * 100) / p : 0, 1'b0});
            last = cap;
         end else begin
            exp_ovr.push_back(cap);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.period_cycles !== '0) begin bad++; $display("FAIL reset_period: got %0d want 0", bus.period_cycles); end
      total++; if (bus.high_cycles !== '0) begin bad++; $display("FAIL reset_high: got %0d want 0", bus.high_cycles); end
      total++; if (bus.duty_percent !== 7'd0) begin bad++; $display("FAIL reset_duty: got %0d want 0", bus.duty_percent); end
      total++; if (bus.meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.meas_valid); end
      total++; if (bus.stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck: got %0b want 0", bus.stuck); end
      total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", bus.overrun); end
      seg(0, 10);
      total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL reset_quiet: got %0d strobes want 0", obs_q.size()); end
   endtask

   task automatic test_fifty();
      do_reset();
      seg(0, 4);
      repeat (4) begin seg(1, 33); seg(0, 33); end
      seg(1, 50);
      build_expected();
      total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL fifty_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         $display("fifty #%0d t=%0d period=%0d high=%0d duty=%0d stuck=%0d", i, obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck);
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL fifty_res%0d: got t=%0d p=%0d h=%0d d=%0d s=%0d want t=%0d p=%0d h=%0d d=%0d s=%0d", i,
                     obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck,
                     exp_q[i].t, exp_q[i].period, exp_q[i].high, exp_q[i].duty, exp_q[i].stuck);
         end
      end
   endtask

   task automatic test_duty_sweep();
      int highs[3] = '{1, 22, 65};
      do_reset();
      seg(0, 4);
      foreach (highs[j]) begin seg(1, highs[j]); seg(0, 66 - highs[j]); end
      seg(1, 50);
      build_expected();
      total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL sweep_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         $display("sweep #%0d t=%0d period=%0d high=%0d duty=%0d stuck=%0d", i, obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck);
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL sweep_res%0d: got t=%0d p=%0d h=%0d d=%0d s=%0d want t=%0d p=%0d h=%0d d=%0d s=%0d", i,
                     obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck,
                     exp_q[i].t, exp_q[i].period, exp_q[i].high, exp_q[i].duty, exp_q[i].stuck);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      seg(0, 4);
      repeat (12) begin
         int p = int'($urandom_range(150, 42));
         int h = int'($urandom_range(p - 1, 1));
         seg(1, h);
         seg(0, p - h);
      end
      seg(1, 50);
      build_expected();
      total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         $display("random #%0d t=%0d period=%0d high=%0d duty=%0d stuck=%0d", i, obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck);
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL random_res%0d: got t=%0d p=%0d h=%0d d=%0d s=%0d want t=%0d p=%0d h=%0d d=%0d s=%0d", i,
                     obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck,
                     exp_q[i].t, exp_q[i].period, exp_q[i].high, exp_q[i].duty, exp_q[i].stuck);
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      seg(0, 4);
      repeat (8) begin seg(1, 7); seg(0, 13); end
      seg(1, 50);
      build_expected();
      total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL ovr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         $display("overrun #%0d t=%0d period=%0d high=%0d duty=%0d stuck=%0d", i, obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck);
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL ovr_res%0d: got t=%0d p=%0d h=%0d d=%0d s=%0d want t=%0d p=%0d h=%0d d=%0d s=%0d", i,
                     obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck,
                     exp_q[i].t, exp_q[i].period, exp_q[i].high, exp_q[i].duty, exp_q[i].stuck);
         end
      end
      total++; if (obs_ovr.size() !== exp_ovr.size()) begin bad++; $display("FAIL ovr_strobes: got %0d want %0d", obs_ovr.size(), exp_ovr.size()); end
      for (int i = 0; i < exp_ovr.size() && i < obs_ovr.size(); i++) begin
         total++;
         $display("overrun strobe #%0d t=%0d", i, obs_ovr[i]);
         if (obs_ovr[i] !== exp_ovr[i]) begin bad++; $display("FAIL ovr_time%0d: got %0d want %0d", i, obs_ovr[i], exp_ovr[i]); end
      end
   endtask

   task automatic test_stuck();
      do_reset();
      seg(0, 4);
      repeat (3) begin seg(1, 33); seg(0, 33); end
      seg(1, 300);
      total++; if (bus.stuck !== 1'b1) begin bad++; $display("FAIL stuck_flag: got %0b want 1", bus.stuck); end
      build_expected();
      exp_q.push_back('{rises[rises.size()-1] + STUCK_LAT, 0, 0, 100, 1'b1});
      rises.delete(); falls.delete();
      seg(0, 20);
      falls.delete();
      repeat (2) begin seg(1, 33); seg(0, 33); end
      seg(1, 50);
      build_expected();
      total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL stuck_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         $display("stuck #%0d t=%0d period=%0d high=%0d duty=%0d stuck=%0d", i, obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck);
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL stuck_res%0d: got t=%0d p=%0d h=%0d d=%0d s=%0d want t=%0d p=%0d h=%0d d=%0d s=%0d", i,
                     obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck,
                     exp_q[i].t, exp_q[i].period, exp_q[i].high, exp_q[i].duty, exp_q[i].stuck);
         end
      end
      total++; if (bus.stuck !== 1'b0) begin bad++; $display("FAIL stuck_clear: got %0b want 0", bus.stuck); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      seg(0, 4);
      repeat (2) begin seg(1, 33); seg(0, 33); end
      seg(1, 50);
      total++; if (bus.period_cycles !== 66) begin bad++; $display("FAIL mid_pre_period: got %0d want 66", bus.period_cycles); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.period_cycles, bus.high_cycles, bus.duty_percent, bus.meas_valid, bus.stuck, bus.overrun} !== '0) begin
         bad++;
         $display("FAIL mid_async_clear: got p=%0d h=%0d d=%0d v=%0b s=%0b o=%0b want all 0",
                  bus.period_cycles, bus.high_cycles, bus.duty_percent, bus.meas_valid, bus.stuck, bus.overrun);
      end
      bus.pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete(); exp_q.delete(); obs_ovr.delete(); exp_ovr.delete();
      rises.delete(); falls.delete();
      seg(0, 5);
      seg(1, 33);
      seg(0, 83);
      total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL mid_one_rise: got %0d strobes want 0", obs_q.size()); end
      seg(1, 33); seg(0, 33);
      seg(1, 50);
      build_expected();
      total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL mid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         $display("reset_mid #%0d t=%0d period=%0d high=%0d duty=%0d stuck=%0d", i, obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck);
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL mid_res%0d: got t=%0d p=%0d h=%0d d=%0d s=%0d want t=%0d p=%0d h=%0d d=%0d s=%0d", i,
                     obs_q[i].t, obs_q[i].period, obs_q[i].high, obs_q[i].duty, obs_q[i].stuck,
                     exp_q[i].t, exp_q[i].period, exp_q[i].high, exp_q[i].duty, exp_q[i].stuck);
         end
      end
   endtask

   initial begin
      bus.pwm_in = 1'b0;
      test_reset();
      test_fifty();
      test_duty_sweep();
      test_random();
      test_overrun();
      test_stuck();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
